// File: rtl/cpu_pkg.sv
// Shared definitions for the 6-phase accumulator CPU (datapath and phase controller).
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b101;

  typedef enum logic [2:0] {
    PH_FETCH  = 3'd0,
    PH_DECODE = 3'd1,
    PH_OPREAD = 3'd2,
    PH_EXEC   = 3'd3,
    PH_WRITE  = 3'd4,
    PH_PC     = 3'd5
  } phase_e;

  // One-hot ALU operation select
  typedef enum logic [3:0] {
    ALU_NONE = 4'b0000,
    ALU_PASS = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0100,
    ALU_AND  = 4'b1000
  } alu_sel_e;

  // Resolve the controller's ALU selects with priority pass > add > sub > and
  function automatic alu_sel_e alu_select(input logic pass, input logic add,
                                          input logic sub, input logic band);
    if (pass)      return ALU_PASS;
    else if (add)  return ALU_ADD;
    else if (sub)  return ALU_SUB;
    else if (band) return ALU_AND;
    else           return ALU_NONE;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: pass / add / subtract / and on the accumulator and operand.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_sel_e     sel,
  output logic [W-1:0] result,
  output logic         carry_out
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the borrow, i.e. a < b
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Select the operation result; with no select the accumulator value passes through
  always_comb begin
    result    = a;
    carry_out = 1'b0;
    case (sel)
      ALU_PASS: result = b;
      ALU_ADD: begin
        result    = w_sum[W-1:0];
        carry_out = w_sum[W];
      end
      ALU_SUB: begin
        result    = w_diff[W-1:0];
        carry_out = w_diff[W];
      end
      ALU_AND: result = a & b;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Execution datapath of the 6-phase accumulator CPU: PC, IR, MDR, ACC, flags and memory strobes.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s0,
  input  logic              s1,
  input  logic              s2,
  input  logic              s3,
  input  logic              s4,
  input  logic              s5,
  input  logic              addrsel,
  input  logic              instr_add,
  input  logic              instr_sub,
  input  logic              instr_and,
  input  logic              instr_pass,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              zero,
  output logic              carry,
  output logic              halted
);

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;
  logic [DATA_W-1:0] r_acc;
  logic              r_carry;
  logic              r_halted;
  logic [2:0]        r_opcode;

  alu_sel_e          w_alu_sel;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_exec;
  logic              w_acc_we;
  logic              w_carry_we;

  // The controller leaves stale selects outside phase 3, so they only count with s3
  assign w_alu_sel  = s3 ? alu_select(instr_pass, instr_add, instr_sub, instr_and) : ALU_NONE;
  assign w_exec     = s3 & ~r_halted;
  assign w_acc_we   = w_exec & (w_alu_sel != ALU_NONE);
  assign w_carry_we = w_exec & ((w_alu_sel == ALU_ADD) | (w_alu_sel == ALU_SUB));

  cpu_alu #(.W(DATA_W)) u_alu (
    .a         (r_acc),
    .b         (r_mdr),
    .sel       (w_alu_sel),
    .result    (w_alu_result),
    .carry_out (w_alu_carry)
  );

  // Fetch into IR, decode opcode, and latch the sticky halt on an HLT decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ir     <= '0;
      r_opcode <= OP_LDA;
      r_halted <= 1'b0;
    end else begin
      if (s0 && !r_halted) r_ir <= mem_rdata;
      if (s1 && !r_halted) begin
        r_opcode <= r_ir[DATA_W-1 -: 3];
        if (r_ir[DATA_W-1 -: 3] == OP_HLT) r_halted <= 1'b1;
      end
    end
  end

  // Operand read into MDR
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_mdr <= '0;
    else if (s2 && !r_halted)  r_mdr <= mem_rdata;
  end

  // Execute: ACC takes the ALU result; carry only changes on ADD/SUB
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
    end else begin
      if (w_acc_we)   r_acc   <= w_alu_result;
      if (w_carry_we) r_carry <= w_alu_carry;
    end
  end

  // PC advance, wrapping naturally at the top of the address space
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 r_pc <= '0;
    else if (s5 && !r_halted)  r_pc <= r_pc + ADDR_W'(1);
  end

  assign mem_addr  = addrsel ? r_ir[ADDR_W-1:0] : r_pc;
  assign mem_re    = (s0 | s2) & ~r_halted & ~reset;
  assign mem_we    = s4 & ~r_halted & ~reset;
  assign mem_wdata = r_acc;

  assign opcode = r_opcode;
  assign acc    = r_acc;
  assign pc     = r_pc;
  assign zero   = (r_acc == '0);
  assign carry  = r_carry;
  assign halted = r_halted;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: behavioural controller + memory, instruction-level reference model, scoreboard.
module tb_cpu_datapath;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0, s5 = 1'b0;
  logic       addrsel = 1'b0;
  logic       instr_add = 1'b0, instr_sub = 1'b0, instr_and = 1'b0, instr_pass = 1'b0;
  logic [2:0] opcode;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_re, mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] acc;
  logic [4:0] pc;
  logic       zero, carry, halted;

  cpu_datapath dut (
    .clock(clock), .reset(reset),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5),
    .addrsel(addrsel),
    .instr_add(instr_add), .instr_sub(instr_sub), .instr_and(instr_and), .instr_pass(instr_pass),
    .opcode(opcode), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .acc(acc), .pc(pc), .zero(zero), .carry(carry), .halted(halted)
  );

  always #5 clock = ~clock;

  // Bench memory seen by the DUT: asynchronous read, write on the clock edge
  logic [7:0] tb_mem [32];
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clock) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  always @(posedge clock)
    assert ($onehot0({s0, s1, s2, s3, s4, s5})) else $error("more than one phase strobe high");

  // Instruction-level reference model
  typedef struct packed {
    logic [4:0] pc;
    logic [7:0] acc;
    logic       carry;
    logic       halted;
    logic [2:0] op;
  } st_t;

  st_t         exp_st_q[$];
  logic [12:0] exp_wr_q[$];
  logic [7:0]  m_mem [32];
  logic [4:0]  m_pc;
  logic [7:0]  m_acc;
  logic        m_carry, m_halted;
  logic [2:0]  m_op;
  logic        mdl_halt = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_acc = '0; m_carry = 1'b0; m_halted = 1'b0; m_op = 3'b000;
    mdl_halt = 1'b0;
  endtask

  task automatic model_exec(output logic hb, output logic ha);
    logic [7:0] ir, opnd;
    logic [8:0] sum;
    hb = m_halted;
    if (!m_halted) begin
      ir   = m_mem[m_pc];
      m_op = ir[7:5];
      opnd = m_mem[ir[4:0]];
      case (m_op)
        OP_LDA: m_acc = opnd;
        OP_STA: begin
          m_mem[ir[4:0]] = m_acc;
          exp_wr_q.push_back({ir[4:0], m_acc});
        end
        OP_ADD: begin
          sum = {1'b0, m_acc} + {1'b0, opnd};
          m_acc = sum[7:0];
          m_carry = sum[8];
        end
        OP_SUB: begin
          m_carry = (m_acc < opnd);
          m_acc = m_acc - opnd;
        end
        OP_AND: m_acc = m_acc & opnd;
        OP_HLT: m_halted = 1'b1;
        default: ;
      endcase
      if (!m_halted) m_pc = m_pc + 5'd1;
    end
    ha = m_halted;
    exp_st_q.push_back('{pc: m_pc, acc: m_acc, carry: m_carry, halted: m_halted, op: m_op});
  endtask

  // Monitor: state after every s5 edge and every memory write are popped and compared
  logic        chk_next = 1'b0;
  initial forever begin
    st_t         e;
    logic [12:0] w;
    @(negedge clock); #1;
    if (reset) begin
      chk_next = 1'b0;
    end else begin
      if (chk_next) begin
        if (exp_st_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL state_q: DUT finished an instruction with no expectation queued");
        end else begin
          e = exp_st_q.pop_front();
          check("pc",     32'(pc),     32'(e.pc));
          check("acc",    32'(acc),    32'(e.acc));
          check("carry",  32'(carry),  32'(e.carry));
          check("halted", 32'(halted), 32'(e.halted));
          check("opcode", 32'(opcode), 32'(e.op));
          check("zero",   32'(zero),   32'(e.acc == 8'h00));
        end
      end
      chk_next = s5;
      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL write_q: unexpected write addr 0x%0h data 0x%0h", mem_addr, mem_wdata);
        end else begin
          w = exp_wr_q.pop_front();
          check("wr_addr", 32'(mem_addr),  32'(w[12:8]));
          check("wr_data", 32'(mem_wdata), 32'(w[7:0]));
        end
      end
      if (s0 || s2) check("mem_re", 32'(mem_re), 32'(!mdl_halt));
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rsel();
    return 4'($urandom_range(0, 15));
  endfunction

  // One controller cycle; sel is {pass, add, sub, and}
  task automatic step(input int ph, input logic en, input logic asel, input logic [3:0] sel);
    logic [5:0] one = 6'b000001;
    @(negedge clock);
    {s5, s4, s3, s2, s1, s0} = en ? (one << ph) : 6'b0;
    addrsel = asel;
    {instr_pass, instr_add, instr_sub, instr_and} = sel;
  endtask

  task automatic idle();
    step(0, 1'b0, rb(), rsel());
    #1;
  endtask

  task automatic run_instr(input logic force_we);
    logic       hb, ha;
    logic [3:0] sel;
    logic [2:0] r;
    model_exec(hb, ha);
    mdl_halt = hb;
    step(PH_FETCH,  1'b1, 1'b0, rsel());
    step(PH_DECODE, 1'b1, rb(), rsel());
    mdl_halt = ha;
    step(PH_OPREAD, 1'b1, 1'b1, rsel());
    r = 3'($urandom_range(0, 7));
    case (opcode)
      OP_LDA:  sel = {1'b1, r};
      OP_ADD:  sel = {2'b01, r[1:0]};
      OP_SUB:  sel = {3'b001, r[0]};
      OP_AND:  sel = 4'b0001;
      default: sel = 4'b0000;
    endcase
    step(PH_EXEC,  1'b1, rb(), sel);
    step(PH_WRITE, force_we || (opcode == OP_STA), 1'b1, rsel());
    step(PH_PC,    1'b1, rb(), rsel());
  endtask

  task automatic load(input int a, input logic [7:0] v);
    tb_mem[a] = v;
    m_mem[a]  = v;
  endtask

  task automatic reset_on();
    idle();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) load(i, 8'h00);
  endtask

  task automatic reset_off();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 32; i++) load(i, 8'h00);

    // Reset state, with strobes that would otherwise enable memory
    @(negedge clock);
    s4 = 1'b1; addrsel = 1'b1;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'(0));
    @(negedge clock);
    s4 = 1'b0; s0 = 1'b1; addrsel = 1'b0;
    #1;
    check("rst_mem_re", 32'(mem_re), 32'(0));
    check("rst_acc",    32'(acc),    32'(0));
    check("rst_pc",     32'(pc),     32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_zero",   32'(zero),   32'(1));
    check("rst_carry",  32'(carry),  32'(0));
    check("rst_opcode", 32'(opcode), 32'(0));
    s0 = 1'b0;

    // LDA 0x10 / ADD 0x11 / STA 0x12 / HLT, then STA-pattern strobes while halted
    reset_on();
    load(0, 8'h10); load(1, 8'h51); load(2, 8'h32); load(3, 8'hA0);
    load(16, 8'h0F); load(17, 8'hF3);
    reset_off();
    for (int i = 0; i < 4; i++) run_instr(1'b0);
    idle();
    check("prog_acc",    32'(acc),        32'(8'h02));
    check("prog_carry",  32'(carry),      32'(1));
    check("prog_halted", 32'(halted),     32'(1));
    check("prog_pc",     32'(pc),         32'(3));
    check("prog_mem12",  32'(tb_mem[18]), 32'(8'h02));
    for (int i = 0; i < 2; i++) run_instr(1'b1);
    idle();
    check("halt_acc", 32'(acc), 32'(8'h02));
    check("halt_pc",  32'(pc),  32'(3));

    // Reset while an LDA of 0x55 is executing
    reset_on();
    load(0, 8'h15); load(21, 8'h33); load(1, 8'h14); load(20, 8'h55);
    reset_off();
    run_instr(1'b0);
    step(PH_FETCH,  1'b1, 1'b0, 4'b0000);
    step(PH_DECODE, 1'b1, 1'b0, 4'b0000);
    step(PH_OPREAD, 1'b1, 1'b1, 4'b0000);
    step(PH_EXEC,   1'b1, 1'b0, 4'b1000);
    #1;
    check("pre_rst_acc", 32'(acc), 32'(8'h33));
    #1;
    reset = 1'b1;
    #1;
    check("midrst_acc",    32'(acc),    32'(0));
    check("midrst_pc",     32'(pc),     32'(0));
    check("midrst_halted", 32'(halted), 32'(0));
    @(negedge clock);
    {s5, s4, s3, s2, s1, s0} = 6'b0;
    reset = 1'b0;
    model_reset();
    @(negedge clock); #1;
    check("post_rst_acc", 32'(acc), 32'(0));
    check("post_rst_pc",  32'(pc),  32'(0));

    // SUB with borrow, AND keeping carry, then NOPs under stale selects
    reset_on();
    load(0, 8'h18); load(24, 8'h03);
    load(1, 8'h79); load(25, 8'h05);
    load(2, 8'h1A); load(26, 8'hF0);
    load(3, 8'h9B); load(27, 8'h3C);
    load(4, 8'hC7); load(5, 8'hE3);
    reset_off();
    run_instr(1'b0); run_instr(1'b0);
    idle();
    check("sub_acc",   32'(acc),   32'(8'hFE));
    check("sub_carry", 32'(carry), 32'(1));
    run_instr(1'b0); run_instr(1'b0);
    idle();
    check("and_acc",   32'(acc),   32'(8'h30));
    check("and_carry", 32'(carry), 32'(1));
    run_instr(1'b0); run_instr(1'b0);
    idle();
    check("nop_acc", 32'(acc), 32'(8'h30));
    check("nop_pc",  32'(pc),  32'(6));

    // PC wrap: NOPs up to address 31, then the fetch at address 0 again
    reset_on();
    for (int i = 1; i < 32; i++) load(i, 8'(8'hC0 | i));
    load(0, 8'h1E);
    reset_off();
    for (int i = 0; i < 32; i++) run_instr(1'b0);
    idle();
    check("wrap_pc",  32'(pc),  32'(0));
    check("wrap_acc", 32'(acc), 32'(8'hDE));
    load(30, 8'h77);
    run_instr(1'b0);
    idle();
    check("wrap_refetch_acc", 32'(acc), 32'(8'h77));
    check("wrap_refetch_pc",  32'(pc),  32'(1));

    // Random programs without HLT
    for (int p = 0; p < 3; p++) begin
      reset_on();
      for (int i = 0; i < 32; i++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b[7:5] == OP_HLT) b = {3'b110, b[4:0]};
        load(i, b);
      end
      reset_off();
      for (int i = 0; i < 40; i++) run_instr(1'b0);
      idle();
    end

    idle();
    check("state_q_drained", 32'(exp_st_q.size()), 32'(0));
    check("write_q_drained", 32'(exp_wr_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
